uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_arbiter_pkg.sv | 17 +
 rtl/uart_tx_arbiter_rr_select.sv | 33 +++
 rtl/uart_tx_arbiter.sv | 139 +++++++++++++
 tb/tb_uart_tx_arbiter.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM encoding,
// requester-count limits and the default busy-handshake timeout.
package uart_tx_arbiter_pkg;

    localparam int NUM_REQ_MIN      = 2;
    localparam int NUM_REQ_MAX      = 4;
    localparam int BUSY_TIMEOUT_DEF = 16;
    localparam int ID_W             = 2;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOAD      = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } arb_state_e;

endpackage

// File: rtl/uart_tx_arbiter_rr_select.sv
// Combinational round-robin picker: first valid requester at or after ptr_i,
// wrapping modulo NUM_REQ.
module rr_select
    import uart_tx_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 3
) (
    input  logic [NUM_REQ-1:0] valid_i,
    input  logic [ID_W-1:0]    ptr_i,
    output logic [ID_W-1:0]    idx_o,
    output logic               any_o
);

    int              pos;
    logic [ID_W-1:0] cand;

    // Scan from the farthest offset down so the nearest valid one wins.
    always_comb begin
        idx_o = '0;
        any_o = 1'b0;
        pos   = 0;
        cand  = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            pos  = int'(ptr_i) + k;
            cand = ID_W'((pos >= NUM_REQ) ? pos - NUM_REQ : pos);
            if (valid_i[cand]) begin
                idx_o = cand;
                any_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that feeds byte packets from NUM_REQ requesters into one
// shared UART byte transmitter; a grant is held until the packet's last byte.
//
//   state     | meaning
//   IDLE      | no owner; pick next requester from rrPtr
//   LOAD      | owner holds grant; waiting for its byte and a free transmitter
//   WAIT_BUSY | txStart high; waiting for txBusy to rise (or timeout)
//   WAIT_DONE | byte in flight; waiting for txBusy to fall
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int NUM_REQ      = 3,
    parameter int BUSY_TIMEOUT = BUSY_TIMEOUT_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     reqValid_i,
    input  logic [8*NUM_REQ-1:0]   reqData_i,
    input  logic [NUM_REQ-1:0]     reqLast_i,
    output logic [NUM_REQ-1:0]     reqReady_o,
    output logic                   txStart_o,
    output logic [7:0]             txData_o,
    input  logic                   txBusy_i,
    output logic                   grantValid_o,
    output logic [ID_W-1:0]        grantId_o,
    output logic                   timeoutErr_o
);

    localparam int              CNT_W    = $clog2(BUSY_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TO_LIMIT = CNT_W'(BUSY_TIMEOUT);
    localparam logic [ID_W-1:0]  LAST_IDX = ID_W'(NUM_REQ - 1);

    arb_state_e       state_q;
    logic [ID_W-1:0]  rrPtr_q, rrPtr_d;
    logic [ID_W-1:0]  grantId_q;
    logic             grantValid_q;
    logic             txStart_q;
    logic [7:0]       txData_q;
    logic             timeoutErr_q;
    logic             last_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [ID_W-1:0]  sel_idx;
    logic             sel_any;
    logic             g_valid, g_last;
    logic [7:0]       g_data;

    rr_select #(.NUM_REQ(NUM_REQ)) u_rr_select (
        .valid_i (reqValid_i),
        .ptr_i   (rrPtr_q),
        .idx_o   (sel_idx),
        .any_o   (sel_any)
    );

    always_comb begin
        g_valid    = 1'b0;
        g_last     = 1'b0;
        g_data     = '0;
        reqReady_o = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grantId_q == ID_W'(i)) begin
                g_valid       = reqValid_i[i];
                g_last        = reqLast_i[i];
                g_data        = reqData_i[8*i +: 8];
                // A busy transmitter blocks the handshake, not just txStart.
                reqReady_o[i] = (state_q == LOAD) && !txBusy_i;
            end
        end
    end

    assign cnt_d   = cnt_q + CNT_W'(1);
    assign rrPtr_d = (grantId_q == LAST_IDX) ? '0 : grantId_q + ID_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            rrPtr_q      <= '0;
            grantId_q    <= '0;
            grantValid_q <= 1'b0;
            txStart_q    <= 1'b0;
            txData_q     <= '0;
            timeoutErr_q <= 1'b0;
            last_q       <= 1'b0;
            cnt_q        <= '0;
        end else begin
            timeoutErr_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (sel_any) begin
                        grantId_q    <= sel_idx;
                        grantValid_q <= 1'b1;
                        state_q      <= LOAD;
                    end
                end
                LOAD: begin
                    if (g_valid && !txBusy_i) begin
                        txData_q  <= g_data;
                        last_q    <= g_last;
                        txStart_q <= 1'b1;
                        cnt_q     <= '0;
                        state_q   <= WAIT_BUSY;
                    end
                end
                WAIT_BUSY: begin
                    if (txBusy_i) begin
                        txStart_q <= 1'b0;
                        state_q   <= WAIT_DONE;
                    end else if (cnt_d == TO_LIMIT) begin
                        txStart_q    <= 1'b0;
                        timeoutErr_q <= 1'b1;
                        state_q      <= WAIT_DONE;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                WAIT_DONE: begin
                    if (!txBusy_i) begin
                        if (last_q) begin
                            rrPtr_q      <= rrPtr_d;
                            grantValid_q <= 1'b0;
                            grantId_q    <= '0;
                            state_q      <= IDLE;
                        end else begin
                            state_q <= LOAD;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign txStart_o    = txStart_q;
    assign txData_o     = txData_q;
    assign grantValid_o = grantValid_q;
    assign grantId_o    = grantId_q;
    assign timeoutErr_o = timeoutErr_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: directed packets per requester, a
// UartTx busy model, and a monitor that checks each byte as txStart rises.
module tb_uart_tx_arbiter;
    import uart_tx_arbiter_pkg::*;

    localparam int N = 3;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   reqValid;
    logic [8*N-1:0] reqData;
    logic [N-1:0]   reqLast;
    logic [N-1:0]   reqReady;
    logic           txStart;
    logic [7:0]     txData;
    logic           txBusy;
    logic           grantValid;
    logic [1:0]     grantId;
    logic           timeoutErr;

    logic model_busy = 1'b0;
    logic force_busy = 1'b0;
    logic model_en   = 1'b1;
    int   busy_len   = 4;
    logic flush      = 1'b0;

    int checks    = 0;
    int errors    = 0;
    int to_pulses = 0;

    // Source entries: {gap_before, last, data}; scoreboard entries: {id, data}.
    logic [9:0] src_q [N][$];
    logic [9:0] sb [$];

    assign txBusy = model_busy | force_busy;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.NUM_REQ(N), .BUSY_TIMEOUT(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .reqValid_i   (reqValid),
        .reqData_i    (reqData),
        .reqLast_i    (reqLast),
        .reqReady_o   (reqReady),
        .txStart_o    (txStart),
        .txData_o     (txData),
        .txBusy_i     (txBusy),
        .grantValid_o (grantValid),
        .grantId_o    (grantId),
        .timeoutErr_o (timeoutErr)
    );

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Requester drivers: one process owns all request inputs.
    initial begin
        int gap [N];
        reqValid = '0;
        reqData  = '0;
        reqLast  = '0;
        for (int i = 0; i < N; i++) gap[i] = 0;
        forever begin
            @(negedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (flush) begin
                    src_q[i].delete();
                    gap[i]      = 0;
                    reqValid[i] = 1'b0;
                end else if (gap[i] > 0) begin
                    gap[i]--;
                    reqValid[i] = 1'b0;
                end else if (src_q[i].size() > 0) begin
                    if (src_q[i][0][9]) begin
                        src_q[i][0][9] = 1'b0;
                        gap[i]         = 4;
                        reqValid[i]    = 1'b0;
                    end else begin
                        reqValid[i]       = 1'b1;
                        reqData[8*i +: 8] = src_q[i][0][7:0];
                        reqLast[i]        = src_q[i][0][8];
                        if (reqReady[i]) void'(src_q[i].pop_front());
                    end
                end else begin
                    reqValid[i] = 1'b0;
                end
            end
        end
    end

    // UartTx model: busy rises one cycle after txStart is seen.
    initial begin
        forever begin
            @(negedge clk);
            if (model_en && txStart && !model_busy) begin
                @(negedge clk);
                model_busy = 1'b1;
                repeat (busy_len) @(negedge clk);
                model_busy = 1'b0;
            end
        end
    end

    // Monitor: compare each started byte against the scoreboard head.
    initial begin
        logic       start_prev;
        logic [9:0] exp;
        start_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (timeoutErr) to_pulses++;
            if (txStart && !start_prev) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_byte: got id %0d data 0x%0h, expected none", grantId, txData);
                end else begin
                    exp = sb.pop_front();
                    check("byte_data", 32'(txData), 32'(exp[7:0]));
                    check("byte_grant_id", 32'(grantId), 32'(exp[9:8]));
                    check("byte_grant_valid", 32'(grantValid), 32'd1);
                end
            end
            start_prev = txStart;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    task automatic wait_idle(input string name, input int budget);
        int n;
        bit done;
        n = 0;
        done = 1'b0;
        while (!done && n < budget) begin
            @(negedge clk);
            n++;
            done = (sb.size() == 0) && (src_q[0].size() == 0) && (src_q[1].size() == 0)
                   && (src_q[2].size() == 0) && !grantValid && !txBusy;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s: idle not reached after %0d cycles, sb=%0d, expected idle", name, n, sb.size());
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk);
        check("rst_txStart", 32'(txStart), 32'd0);
        check("rst_txData", 32'(txData), 32'd0);
        check("rst_grantValid", 32'(grantValid), 32'd0);
        check("rst_grantId", 32'(grantId), 32'd0);
        check("rst_timeoutErr", 32'(timeoutErr), 32'd0);
        check("rst_reqReady", 32'(reqReady), 32'd0);
        check("rst_state", 32'(dut.state_q), 32'(IDLE));
        check("rst_rrPtr", 32'(dut.rrPtr_q), 32'd0);
        rst = 1'b0;

        // Two-byte packet from requester 1.
        sb.push_back({2'd1, 8'h41});
        sb.push_back({2'd1, 8'h0A});
        src_q[1].push_back({1'b0, 1'b0, 8'h41});
        src_q[1].push_back({1'b0, 1'b1, 8'h0A});
        wait_idle("t1_idle", 200);
        check("t1_rrPtr", 32'(dut.rrPtr_q), 32'd2);
        check("t1_grantValid", 32'(grantValid), 32'd0);

        // All three valid from reset: order 0,1,2 then 0 again.
        do_reset();
        sb.push_back({2'd0, 8'hA0});
        sb.push_back({2'd1, 8'hB1});
        sb.push_back({2'd2, 8'hC2});
        sb.push_back({2'd0, 8'hA3});
        src_q[0].push_back({1'b0, 1'b1, 8'hA0});
        src_q[0].push_back({1'b0, 1'b1, 8'hA3});
        src_q[1].push_back({1'b0, 1'b1, 8'hB1});
        src_q[2].push_back({1'b0, 1'b1, 8'hC2});
        wait_idle("t2_idle", 400);
        check("t2_rrPtr", 32'(dut.rrPtr_q), 32'd1);

        // Requester 2 stalls mid-packet; requester 0 must wait for its last byte.
        sb.push_back({2'd2, 8'h31});
        sb.push_back({2'd2, 8'h32});
        sb.push_back({2'd2, 8'h33});
        sb.push_back({2'd0, 8'h04});
        src_q[2].push_back({1'b0, 1'b0, 8'h31});
        src_q[2].push_back({1'b1, 1'b0, 8'h32});
        src_q[2].push_back({1'b0, 1'b1, 8'h33});
        src_q[0].push_back({1'b0, 1'b1, 8'h04});
        wait_idle("t3_idle", 400);

        // Transmitter never goes busy: timeout after 16 cycles.
        model_en = 1'b0;
        sb.push_back({2'd1, 8'h55});
        src_q[1].push_back({1'b0, 1'b1, 8'h55});
        n = 0;
        while (!txStart && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("t4_start_seen", 32'(txStart), 32'd1);
        n = 0;
        while (txStart && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("t4_timeout_latency", 32'(n), 32'd16);
        check("t4_timeout_pulse", 32'(timeoutErr), 32'd1);
        @(negedge clk);
        check("t4_timeout_width", 32'(timeoutErr), 32'd0);
        wait_idle("t4_idle", 50);
        check("t4_rrPtr", 32'(dut.rrPtr_q), 32'd2);
        model_en = 1'b1;

        // Reset during WAIT_DONE of byte 1 of 3.
        busy_len = 6;
        sb.push_back({2'd0, 8'h61});
        src_q[0].push_back({1'b0, 1'b0, 8'h61});
        src_q[0].push_back({1'b0, 1'b0, 8'h62});
        src_q[0].push_back({1'b0, 1'b1, 8'h63});
        n = 0;
        while (dut.state_q != WAIT_DONE && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("t5_reach_wait_done", 32'(dut.state_q), 32'(WAIT_DONE));
        #2;
        rst   = 1'b1;
        flush = 1'b1;
        #1;
        check("t5_async_txStart", 32'(txStart), 32'd0);
        check("t5_async_txData", 32'(txData), 32'd0);
        check("t5_async_grantValid", 32'(grantValid), 32'd0);
        check("t5_async_grantId", 32'(grantId), 32'd0);
        check("t5_async_reqReady", 32'(reqReady), 32'd0);
        check("t5_async_state", 32'(dut.state_q), 32'(IDLE));
        repeat (2) @(negedge clk);
        rst   = 1'b0;
        flush = 1'b0;
        n = 0;
        while (model_busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("t5_post_state", 32'(dut.state_q), 32'(IDLE));
        check("t5_post_rrPtr", 32'(dut.rrPtr_q), 32'd0);
        repeat (5) @(negedge clk);
        check("t5_no_resend", 32'(grantValid), 32'd0);
        check("t5_sb_empty", 32'(sb.size()), 32'd0);

        // Transmitter already busy before the grant: hold in LOAD.
        do_reset();
        model_en   = 1'b0;
        force_busy = 1'b1;
        busy_len   = 4;
        sb.push_back({2'd0, 8'h77});
        src_q[0].push_back({1'b0, 1'b1, 8'h77});
        repeat (6) @(negedge clk);
        check("t6_stall_txStart", 32'(txStart), 32'd0);
        check("t6_stall_state", 32'(dut.state_q), 32'(LOAD));
        check("t6_stall_reqReady", 32'(reqReady), 32'd0);
        check("t6_stall_grant", 32'({grantValid, grantId}), 32'h4);
        force_busy = 1'b0;
        model_en   = 1'b1;
        wait_idle("t6_idle", 100);

        check("timeout_pulse_count", 32'(to_pulses), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
